// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - opcode map (OP_ADD .. OP_ROR)
//   - FSM state encoding (state_t)
//   - is_illegal(): decode of the three unused opcodes
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_NEG  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1010;
  localparam logic [3:0] OP_SHRA = 4'b1011;
  localparam logic [3:0] OP_SHL  = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1101;
  localparam logic [3:0] OP_ROL  = 4'b1110;
  localparam logic [3:0] OP_ROR  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_illegal(input logic [3:0] sel);
    return (sel == 4'b0000) || (sel == 4'b0100) || (sel == 4'b1001);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: unsigned iterative multiplier / restoring divider.
//   One WIDTH+1 bit adder and a {hi,lo} 2*WIDTH shift register are shared by
//   both operations; one bit is processed per cycle, WIDTH cycles per op.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (aborts a running op)
//   i_go        load operands and start (single-cycle pulse)
//   i_div       0 = multiply i_a*i_b, 1 = divide i_a/i_b
//   i_a, i_b    unsigned operands (multiplier/multiplicand, dividend/divisor)
//   o_rdy       high once the result is final, held until the next i_go
//   o_hi, o_lo  MUL: product {hi,lo};  DIV: hi = remainder, lo = quotient
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_go,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_rdy,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_hi, r_lo, r_opnd;
  logic [CW-1:0]    r_cnt;
  logic             r_run, r_rdy, r_div;

  logic [WIDTH:0]   w_x, w_y;
  logic             w_cin;
  logic [WIDTH+1:0] w_sum;

  // Shared adder. MUL: hi + (lo[0] ? opnd : 0). DIV: {hi,lo[msb]} - opnd,
  // where the carry-out (bit WIDTH+1) set means "no borrow" -> quotient bit 1.
  always_comb begin
    if (r_div) begin
      w_x   = {r_hi, r_lo[WIDTH-1]};
      w_y   = ~{1'b0, r_opnd};
      w_cin = 1'b1;
    end else begin
      w_x   = {1'b0, r_hi};
      w_y   = r_lo[0] ? {1'b0, r_opnd} : '0;
      w_cin = 1'b0;
    end
    w_sum = {1'b0, w_x} + {1'b0, w_y} + {{(WIDTH+1){1'b0}}, w_cin};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_rdy  <= 1'b0;
      r_div  <= 1'b0;
    end else if (i_go) begin
      r_hi   <= '0;
      r_lo   <= i_a;
      r_opnd <= i_b;
      r_div  <= i_div;
      r_cnt  <= '0;
      r_run  <= 1'b1;
      r_rdy  <= 1'b0;
    end else if (r_run) begin
      if (r_div) begin
        if (w_sum[WIDTH+1]) begin
          r_hi <= w_sum[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b1};
        end else begin
          r_hi <= w_x[WIDTH-1:0];       // restore: keep the shifted remainder
          r_lo <= {r_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        r_hi <= w_sum[WIDTH:1];
        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
      end
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CW'(WIDTH - 1)) begin
        r_run <= 1'b0;
        r_rdy <= 1'b1;
      end
    end
  end

  assign o_rdy = r_rdy;
  assign o_hi  = r_hi;
  assign o_lo  = r_lo;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle signed ALU with start/busy/done handshake.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               request, accepted on a rising edge when busy=0
//   select, A, B        opcode and signed operands, captured at accept
//   Z                   {Hi,Lo} result, held until the next done
//   carry, overflow,
//   div_zero, illegal   status flags, valid with done, cleared at next accept
//   busy                high from the accept edge until the edge raising done
//   done                one-cycle pulse, Z and flags valid from this cycle
//   o_dbg_state         current FSM state (state_t encoding)
// Handshake: a request is taken on any rising edge where start=1 and busy=0
// (IDLE or DONE). While busy=1, start is ignored and nothing is queued;
// exactly one done pulse follows each accepted request unless reset intervenes.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         select,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Z,
  output logic               carry,
  output logic               overflow,
  output logic               div_zero,
  output logic               illegal,
  output logic               busy,
  output logic               done,
  output logic [1:0]         o_dbg_state
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [3:0]         r_sel;
  logic [2*WIDTH-1:0] r_z;
  logic               r_carry, r_ovf, r_dz, r_ill;

  logic w_accept, w_go, w_iter_op, w_it_rdy;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_it_hi, w_it_lo;

  // MUL and DIV by non-zero go through the iterator; DIV by zero is resolved
  // in one cycle.
  assign w_iter_op = (select == OP_MUL) || ((select == OP_DIV) && (B != '0));
  assign w_mag_a   = A[WIDTH-1] ? -A : A;
  assign w_mag_b   = B[WIDTH-1] ? -B : B;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .i_go  (w_go),
    .i_div (select == OP_DIV),
    .i_a   (w_mag_a),
    .i_b   (w_mag_b),
    .o_rdy (w_it_rdy),
    .o_hi  (w_it_hi),
    .o_lo  (w_it_lo)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_go        = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        w_state_nxt = ST_IDLE;
        if (start) begin
          w_accept    = 1'b1;
          w_go        = w_iter_op;
          w_state_nxt = w_iter_op ? ST_ITER : ST_EXEC;
        end
      end
      ST_EXEC: w_state_nxt = ST_DONE;
      ST_ITER: if (w_it_rdy) w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- single-cycle datapath ----------------
  logic [SHW-1:0]   w_amt;
  logic [SHW:0]     w_ramt;
  logic [WIDTH:0]   w_add, w_sub;
  logic [WIDTH-1:0] w_e_lo, w_e_hi;
  logic             w_e_c, w_e_v, w_e_dz;

  assign w_amt  = r_b[SHW-1:0];
  // Complementary rotate amount; WIDTH-0 = WIDTH shifts everything out.
  assign w_ramt = (SHW+1)'(WIDTH) - {1'b0, w_amt};
  assign w_add  = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub  = {1'b0, r_a} + {1'b0, ~r_b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    w_e_lo = '0;
    w_e_hi = '0;
    w_e_c  = 1'b0;
    w_e_v  = 1'b0;
    w_e_dz = 1'b0;
    case (r_sel)
      OP_ADD: begin
        w_e_lo = w_add[WIDTH-1:0];
        w_e_c  = w_add[WIDTH];
        w_e_v  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_e_lo = w_sub[WIDTH-1:0];
        w_e_c  = w_sub[WIDTH];
        w_e_v  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_DIV: begin                    // only reaches EXEC with B==0
        w_e_lo = '1;
        w_e_hi = r_a;
        w_e_dz = 1'b1;
      end
      OP_AND:  w_e_lo = r_a & r_b;
      OP_OR:   w_e_lo = r_a | r_b;
      OP_NEG: begin
        w_e_lo = -r_a;
        w_e_v  = (r_a == MIN_VAL);
      end
      OP_NOT:  w_e_lo = ~r_a;
      OP_SHL:  w_e_lo = r_a << w_amt;
      OP_SHR:  w_e_lo = r_a >> w_amt;
      OP_SHRA: w_e_lo = WIDTH'($signed(r_a) >>> w_amt);
      OP_ROL:  w_e_lo = (r_a << w_amt) | (r_a >> w_ramt);
      OP_ROR:  w_e_lo = (r_a >> w_amt) | (r_a << w_ramt);
      default: ;
    endcase
  end

  // ---------------- sign post-processing for MUL/DIV ----------------
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0]   w_quo_s, w_rem_s;
  logic               w_div_ovf;

  assign w_prod    = {w_it_hi, w_it_lo};
  assign w_prod_s  = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -w_prod : w_prod;
  assign w_quo_s   = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -w_it_lo : w_it_lo;
  assign w_rem_s   = r_a[WIDTH-1] ? -w_it_hi : w_it_hi;   // remainder follows A
  assign w_div_ovf = (r_a == MIN_VAL) && (r_b == '1);

  // ---------------- capture, result and flag registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_z     <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_dz    <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= A;
        r_b     <= B;
        r_sel   <= select;
        r_carry <= 1'b0;
        r_ovf   <= 1'b0;
        r_dz    <= 1'b0;
        r_ill   <= 1'b0;
      end
      if (r_state == ST_EXEC) begin
        if (is_illegal(r_sel)) begin
          r_ill <= 1'b1;                 // Z keeps the previous result
        end else begin
          r_z     <= {w_e_hi, w_e_lo};
          r_carry <= w_e_c;
          r_ovf   <= w_e_v;
          r_dz    <= w_e_dz;
        end
      end else if ((r_state == ST_ITER) && w_it_rdy) begin
        if (r_sel == OP_MUL) begin
          r_z <= w_prod_s;
        end else begin
          r_z   <= {w_rem_s, w_quo_s};
          r_ovf <= w_div_ovf;
        end
      end
    end
  end

  assign Z           = r_z;
  assign carry       = r_carry;
  assign overflow    = r_ovf;
  assign div_zero    = r_dz;
  assign illegal     = r_ill;
  assign busy        = (r_state == ST_EXEC) || (r_state == ST_ITER);
  assign done        = (r_state == ST_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=32).
module tb_alu_seq;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           start = 1'b0;
  logic [3:0]     select = 4'b0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic [2*W-1:0] Z;
  logic           carry, overflow, div_zero, illegal, busy, done;
  logic [1:0]     dbg_state;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .select      (select),
    .A           (A),
    .B           (B),
    .Z           (Z),
    .carry       (carry),
    .overflow    (overflow),
    .div_zero    (div_zero),
    .illegal     (illegal),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] flags4();
    return {60'b0, carry, overflow, div_zero, illegal};
  endfunction

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] z;
    logic [3:0]  fl;   // {carry, overflow, div_zero, illegal}
    logic [7:0]  lat;
  } vec_t;
  vec_t vq[$];

  task automatic add_vec(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] z, input logic [3:0] fl, input logic [7:0] lat);
    vec_t v;
    v.sel = sel; v.a = a; v.b = b; v.z = z; v.fl = fl; v.lat = lat;
    vq.push_back(v);
  endtask

  // ---------------- driver ----------------
  // Presents one request, scrambles the inputs after the accept edge, and
  // waits (bounded) for done. Returns the accept-to-done edge count.
  task automatic run_op(input string tag, input logic [3:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input bit b2b, output int lat);
    bit busy_ok;
    if (!b2b) @(negedge clk);
    start = 1'b1; select = sel; A = a; B = b;
    @(posedge clk); #1;
    start  = 1'b0;
    A      = $urandom;
    B      = $urandom;
    select = 4'($urandom_range(0, 15));
    check({tag, "/clr"}, flags4(), 64'h0);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/busy"}, 64'(busy_ok), 64'h1);
  endtask

  int lat;
  int n_done;
  logic [2*W-1:0] ez;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst/Z", Z, 64'h0);
    check("rst/flags", flags4(), 64'h0);
    check("rst/busy", 64'(busy), 64'h0);
    check("rst/done", 64'(done), 64'h0);
    check("rst/state", 64'(dbg_state), 64'h0);
    rst_n = 1'b1;

    add_vec(4'b0001, 32'hFFFFFFFF, 32'h00000001, 64'h0,                   4'b1000, 1);
    add_vec(4'b0001, 32'h7FFFFFFF, 32'h00000001, 64'h00000000_80000000, 4'b0100, 1);
    add_vec(4'b0010, 32'h00000005, 32'h00000007, 64'h00000000_FFFFFFFE, 4'b0000, 1);
    add_vec(4'b0010, 32'h00000007, 32'h00000005, 64'h00000000_00000002, 4'b1000, 1);
    add_vec(4'b0010, 32'h80000000, 32'h00000001, 64'h00000000_7FFFFFFF, 4'b1100, 1);
    add_vec(4'b0011, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 4'b0000, 33);
    add_vec(4'b0011, 32'h00010000, 32'h00010000, 64'h00000001_00000000, 4'b0000, 33);
    add_vec(4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 4'b0000, 33);
    add_vec(4'b0101, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 4'b0000, 33);
    add_vec(4'b0101, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 4'b0000, 33);
    add_vec(4'b0101, 32'h00000005, 32'h00000000, 64'h00000005_FFFFFFFF, 4'b0010, 1);
    add_vec(4'b0101, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 4'b0100, 33);
    add_vec(4'b0101, 32'h00000064, 32'h00000007, 64'h00000002_0000000E, 4'b0000, 33);
    add_vec(4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 64'h00000000_00F000F0, 4'b0000, 1);
    add_vec(4'b0111, 32'hF0F0F0F0, 32'h0F0F0000, 64'h00000000_FFFFF0F0, 4'b0000, 1);
    add_vec(4'b1000, 32'h00000005, 32'h00000000, 64'h00000000_FFFFFFFB, 4'b0000, 1);
    add_vec(4'b1000, 32'h80000000, 32'h00000000, 64'h00000000_80000000, 4'b0100, 1);
    add_vec(4'b1010, 32'h12345678, 32'h00000000, 64'h00000000_EDCBA987, 4'b0000, 1);
    add_vec(4'b1100, 32'h00000001, 32'h0000001F, 64'h00000000_80000000, 4'b0000, 1);
    add_vec(4'b1100, 32'h00000003, 32'h00000024, 64'h00000000_00000030, 4'b0000, 1);
    add_vec(4'b1101, 32'h80000000, 32'h0000001F, 64'h00000000_00000001, 4'b0000, 1);
    add_vec(4'b1011, 32'h80000000, 32'h00000004, 64'h00000000_F8000000, 4'b0000, 1);
    add_vec(4'b0100, 32'h11111111, 32'h22222222, 64'h00000000_F8000000, 4'b0001, 1);
    add_vec(4'b1011, 32'h40000000, 32'h00000004, 64'h00000000_04000000, 4'b0000, 1);
    add_vec(4'b1110, 32'h80000001, 32'h00000021, 64'h00000000_00000003, 4'b0000, 1);
    add_vec(4'b1111, 32'h00000001, 32'h00000001, 64'h00000000_80000000, 4'b0000, 1);
    add_vec(4'b1110, 32'h12345678, 32'h00000000, 64'h00000000_12345678, 4'b0000, 1);
    add_vec(4'b1001, 32'h00000001, 32'h00000001, 64'h00000000_12345678, 4'b0001, 1);
    add_vec(4'b0000, 32'h00000001, 32'h00000001, 64'h00000000_12345678, 4'b0001, 1);

    foreach (vq[i]) begin
      string tag;
      tag = $sformatf("v%0d_op%b", i, vq[i].sel);
      exp_q.push_back(vq[i].z);
      run_op(tag, vq[i].sel, vq[i].a, vq[i].b, 1'b0, lat);
      ez = exp_q.pop_front();
      check({tag, "/lat"}, 64'(lat), 64'(vq[i].lat));
      check({tag, "/Z"}, Z, ez);
      check({tag, "/flags"}, flags4(), 64'(vq[i].fl));
      check({tag, "/busy_at_done"}, 64'(busy), 64'h0);
      @(posedge clk); #1;
      check({tag, "/pulse"}, 64'(done), 64'h0);
      check({tag, "/Zheld"}, Z, ez);
    end

    // start pulsed while a MUL is busy is ignored
    @(negedge clk);
    start = 1'b1; select = 4'b0011; A = 32'd3; B = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 5) begin
        start = 1'b1; select = 4'b0001; A = 32'd1; B = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("ign/lat", 64'(lat), 64'd33);
    check("ign/Z", Z, 64'd12);
    n_done = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("ign/extra_done", 64'(n_done), 64'd0);

    // reset at cycle 10 of a MUL aborts it
    @(negedge clk);
    start = 1'b1; select = 4'b0011; A = 32'd5; B = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("abort/busy_before", 64'(busy), 64'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort/busy", 64'(busy), 64'h0);
    check("abort/Z", Z, 64'h0);
    check("abort/done", 64'(done), 64'h0);
    check("abort/state", 64'(dbg_state), 64'h0);
    n_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("abort/no_done", 64'(n_done), 64'd0);

    // back-to-back: start presented in the DONE cycle is accepted
    run_op("b2b0", 4'b0001, 32'd1, 32'd2, 1'b0, lat);
    check("b2b0/lat", 64'(lat), 64'd1);
    check("b2b0/Z", Z, 64'd3);
    run_op("b2b1", 4'b0001, 32'd3, 32'd4, 1'b1, lat);
    check("b2b1/lat", 64'(lat), 64'd1);
    check("b2b1/Z", Z, 64'd7);
    run_op("b2b2", 4'b0011, 32'd2, 32'hFFFFFFFD, 1'b1, lat);
    check("b2b2/lat", 64'(lat), 64'd33);
    check("b2b2/Z", Z, 64'hFFFFFFFF_FFFFFFFA);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
